icache_refill_ctrl: RTL and testbench

Instruction-cache refill controller in the fetch path, in the `cpu_clk` domain, directly upstream of the AXI read-request CDC stage. On an I-cache miss it line-aligns the address and issues one INCR burst request through a valid/ready handshake. It then collects the returning read beats into a full cache line and presents the line to the cache with a one-cycle pulse. Bus errors and protocol violations are reported, and flush-abort is supported.

---
 rtl/imem_pkg.sv | 17 +
 rtl/icache_line_buf.sv | 46 ++++
 rtl/icache_refill_ctrl.sv | 159 +++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory refill path.
//   AXI_BURST_INCR / AXI_SIZE_8B / AXI_RESP_OKAY : fixed AXI read-channel encodings
//   refill_state_e                              : refill controller state encoding
package imem_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_line_buf.sv
// Cache-line assembly buffer: BEATS registers of 64 bits, one written per cycle.
//   clk, rst   : clock, asynchronous active-high reset (clears all slots)
//   wr_en_i    : write slot wr_idx_i with wr_data_i this cycle
//   wr_idx_i   : slot index
//   wr_data_i  : beat data
//   line_o     : flattened line, slot i at bits [64i+63:64i]
module icache_line_buf #(
    parameter int BEATS = 8,
    parameter int IDX_W = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [63:0]           wr_data_i,
    output logic [BEATS*64-1:0]   line_o
);

    logic [63:0] mem_q [BEATS];
    logic [63:0] mem_d [BEATS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            mem_d[wr_idx_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BEATS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        line_o = '0;
        for (int i = 0; i < BEATS; i++) begin
            line_o[64*i +: 64] = mem_q[i];
        end
    end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill controller: accepts a miss, issues one line-aligned INCR read
// burst, assembles the returned beats into a line and pulses it to the cache.
//   cpu_clk, cpu_reset          : clock, asynchronous active-high reset
//   miss_valid_i/miss_addr_i    : miss request; miss_ready_o high when idle
//   flush_i                     : discard the refill in flight (burst still drained)
//   ar*_o / arready_i           : read-address request to the CDC stage
//   rdata_i/rresp_i/rlast_i/rvalid_i, rready_o : read-data beats
//   line_valid_o/line_addr_o/line_data_o/line_err_o : completed line
module icache_refill_ctrl
    import imem_pkg::*;
#(
    parameter int LINE_BYTES = 64
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_reset,
    input  logic                      miss_valid_i,
    input  logic [63:0]               miss_addr_i,
    output logic                      miss_ready_o,
    input  logic                      flush_i,
    output logic [63:0]               araddr_o,
    output logic [7:0]                arlen_o,
    output logic [2:0]                arsize_o,
    output logic [1:0]                arburst_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    input  logic [63:0]               rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    output logic                      line_valid_o,
    output logic [63:0]               line_addr_o,
    output logic [LINE_BYTES*8-1:0]   line_data_o,
    output logic                      line_err_o
);

    // state   | meaning
    // IDLE    | waiting for a miss
    // REQ     | burst request presented, waiting for arready
    // RESP    | accepting read beats until rlast
    // DONE    | one-cycle line delivery pulse

    localparam int BEATS = LINE_BYTES / 8;
    localparam int IDX_W = $clog2(BEATS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] BEATS_C  = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(BEATS - 1);
    localparam logic [63:0]      OFF_MASK = 64'(LINE_BYTES - 1);

    refill_state_e    state_q, state_d;
    logic [63:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             drop_q, drop_d;
    logic             miss_ready_q, miss_ready_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic             line_valid_q, line_valid_d;
    logic             line_err_q, line_err_d;
    logic             wr_en;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss_valid_i && miss_ready_q) begin
                    addr_d  = miss_addr_i & ~OFF_MASK;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A flush cannot retract an offered request; it only marks the result for discard.
                if (flush_i) drop_d = 1'b1;
                if (arvalid_q && arready_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (flush_i) drop_d = 1'b1;
                if (rready_q && rvalid_i) begin
                    if (cnt_q < BEATS_C) wr_en = 1'b1;
                    else                 err_d = 1'b1;
                    // Saturating so an over-long burst can never wrap onto valid slots.
                    if (cnt_q != BEATS_C) cnt_d = cnt_q + CNT_W'(1);
                    if (rresp_i != AXI_RESP_OKAY) err_d = 1'b1;
                    if (rlast_i) begin
                        if (cnt_q != LAST_C) err_d = 1'b1;
                        state_d = drop_d ? ST_IDLE : ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs registered from the next state so they are glitch-free.
        miss_ready_d = (state_d == ST_IDLE);
        arvalid_d    = (state_d == ST_REQ);
        rready_d     = (state_d == ST_RESP);
        line_valid_d = (state_d == ST_DONE);
        line_err_d   = (state_d == ST_DONE) && err_d;
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;
            miss_ready_q <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            line_valid_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            drop_q       <= drop_d;
            miss_ready_q <= miss_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            line_valid_q <= line_valid_d;
            line_err_q   <= line_err_d;
        end
    end

    icache_line_buf #(
        .BEATS (BEATS),
        .IDX_W (IDX_W)
    ) u_line_buf (
        .clk       (cpu_clk),
        .rst       (cpu_reset),
        .wr_en_i   (wr_en),
        .wr_idx_i  (cnt_q[IDX_W-1:0]),
        .wr_data_i (rdata_i),
        .line_o    (line_data_o)
    );

    assign miss_ready_o = miss_ready_q;
    assign araddr_o     = addr_q;
    assign arlen_o      = 8'(BEATS - 1);
    assign arsize_o     = AXI_SIZE_8B;
    assign arburst_o    = AXI_BURST_INCR;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign line_valid_o = line_valid_q;
    assign line_addr_o  = addr_q;
    assign line_err_o   = line_err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl with LINE_BYTES=64 (8 beats per line).
module tb_icache_refill_ctrl;

    logic          cpu_clk = 1'b0;
    logic          cpu_reset;
    logic          miss_valid_i;
    logic [63:0]   miss_addr_i;
    logic          miss_ready_o;
    logic          flush_i;
    logic [63:0]   araddr_o;
    logic [7:0]    arlen_o;
    logic [2:0]    arsize_o;
    logic [1:0]    arburst_o;
    logic          arvalid_o;
    logic          arready_i;
    logic [63:0]   rdata_i;
    logic [1:0]    rresp_i;
    logic          rlast_i;
    logic          rvalid_i;
    logic          rready_o;
    logic          line_valid_o;
    logic [63:0]   line_addr_o;
    logic [511:0]  line_data_o;
    logic          line_err_o;

    int n_asserts = 0;
    int n_fail    = 0;
    int lv_cnt    = 0;
    int stalls;

    icache_refill_ctrl #(.LINE_BYTES(64)) dut (
        .cpu_clk      (cpu_clk),
        .cpu_reset    (cpu_reset),
        .miss_valid_i (miss_valid_i),
        .miss_addr_i  (miss_addr_i),
        .miss_ready_o (miss_ready_o),
        .flush_i      (flush_i),
        .araddr_o     (araddr_o),
        .arlen_o      (arlen_o),
        .arsize_o     (arsize_o),
        .arburst_o    (arburst_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rlast_i      (rlast_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .line_valid_o (line_valid_o),
        .line_addr_o  (line_addr_o),
        .line_data_o  (line_data_o),
        .line_err_o   (line_err_o)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(negedge cpu_clk) begin
        if (line_valid_o === 1'b1) lv_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " miss_ready"}, 64'(miss_ready_o), 64'd0);
        chk({tag, " arvalid"},    64'(arvalid_o),    64'd0);
        chk({tag, " rready"},     64'(rready_o),     64'd0);
        chk({tag, " line_valid"}, 64'(line_valid_o), 64'd0);
        chk({tag, " line_err"},   64'(line_err_o),   64'd0);
        chk({tag, " araddr"},     araddr_o,          64'd0);
        chk({tag, " line_addr"},  line_addr_o,       64'd0);
        chk({tag, " line_slot0"}, line_data_o[63:0], 64'd0);
        chk({tag, " arlen"},      64'(arlen_o),      64'd7);
        chk({tag, " arsize"},     64'(arsize_o),     64'd3);
        chk({tag, " arburst"},    64'(arburst_o),    64'd1);
    endtask

    // Accept a miss and complete the AR handshake with no wait.
    task automatic run_miss(input logic [63:0] addr, input logic [63:0] exp_aligned);
        miss_valid_i = 1'b1;
        miss_addr_i  = addr;
        tick();
        miss_valid_i = 1'b0;
        chk("req arvalid", 64'(arvalid_o), 64'd1);
        chk("req araddr",  araddr_o,       exp_aligned);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        chk("resp rready", 64'(rready_o), 64'd1);
    endtask

    // Drive n beats; data = base+i. Returns the number of cycles rready was low.
    task automatic send_beats(input int n, input int last_idx, input logic [63:0] base,
                              input int bad_idx, input int flush_idx, output int stall_cnt);
        logic sampled;
        int   guard;
        stall_cnt = 0;
        for (int i = 0; i < n; i++) begin
            rvalid_i = 1'b1;
            rdata_i  = base + 64'(i);
            rresp_i  = (i == bad_idx) ? 2'b10 : 2'b00;
            rlast_i  = (i == last_idx);
            flush_i  = (i == flush_idx);
            guard    = 0;
            do begin
                sampled = rready_o;
                if (!sampled) stall_cnt++;
                tick();
                guard++;
            end while (!sampled && guard < 20);
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        rresp_i  = 2'b00;
        flush_i  = 1'b0;
    endtask

    initial begin
        cpu_reset    = 1'b1;
        miss_valid_i = 1'b0;
        miss_addr_i  = '0;
        flush_i      = 1'b0;
        arready_i    = 1'b0;
        rdata_i      = '0;
        rresp_i      = 2'b00;
        rlast_i      = 1'b0;
        rvalid_i     = 1'b0;

        tick();
        tick();
        chk_reset_outputs("rst");
        cpu_reset = 1'b0;
        tick();
        chk("post-rst miss_ready", 64'(miss_ready_o), 64'd1);

        // Basic line fill.
        run_miss(64'h1234, 64'h1200);
        send_beats(8, 7, 64'd0, -1, -1, stalls);
        chk("t1 stalls",     64'(stalls),       64'd0);
        chk("t1 line_valid", 64'(line_valid_o), 64'd1);
        chk("t1 line_err",   64'(line_err_o),   64'd0);
        chk("t1 miss_ready", 64'(miss_ready_o), 64'd0);
        chk("t1 line_addr",  line_addr_o,       64'h1200);
        for (int i = 0; i < 8; i++) chk($sformatf("t1 slot%0d", i), line_data_o[64*i +: 64], 64'(i));
        tick();
        chk("t1 pulse end",  64'(line_valid_o), 64'd0);
        chk("t1 ready back", 64'(miss_ready_o), 64'd1);
        chk("t1 hold addr",  line_addr_o,       64'h1200);
        chk("t1 pulses",     64'(lv_cnt),       64'd1);

        // AR back-pressure for 10 cycles; an early rvalid must not be taken.
        miss_valid_i = 1'b1;
        miss_addr_i  = 64'h5678;
        tick();
        miss_valid_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = 64'hBAD;
        rlast_i  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t2 arvalid hold", 64'(arvalid_o), 64'd1);
            chk("t2 araddr hold",  araddr_o,       64'h5640);
            chk("t2 rready low",   64'(rready_o),  64'd0);
            tick();
        end
        chk("t2 rready before hs", 64'(rready_o), 64'd0);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        rlast_i   = 1'b0;
        chk("t2 rready after hs", 64'(rready_o),  64'd1);
        chk("t2 arvalid drop",    64'(arvalid_o), 64'd0);
        send_beats(8, 7, 64'h500, -1, -1, stalls);
        chk("t2 line_valid", 64'(line_valid_o), 64'd1);
        chk("t2 line_err",   64'(line_err_o),   64'd0);
        chk("t2 slot0",      line_data_o[63:0], 64'h500);
        chk("t2 slot7",      line_data_o[511:448], 64'h507);
        tick();

        // Error response on beat 3.
        run_miss(64'h2000, 64'h2000);
        send_beats(8, 7, 64'h300, 3, -1, stalls);
        chk("t3 line_valid", 64'(line_valid_o), 64'd1);
        chk("t3 line_err",   64'(line_err_o),   64'd1);
        tick();

        // Early rlast on beat 5.
        run_miss(64'h3fff, 64'h3fc0);
        send_beats(6, 5, 64'h400, -1, -1, stalls);
        chk("t4 line_valid", 64'(line_valid_o), 64'd1);
        chk("t4 line_err",   64'(line_err_o),   64'd1);
        chk("t4 slot5",      line_data_o[383:320], 64'h405);
        tick();

        // Late rlast on beat 9: beats 8 and 9 dropped.
        run_miss(64'h4040, 64'h4040);
        send_beats(10, 9, 64'h100, -1, -1, stalls);
        chk("t5 stalls",     64'(stalls),       64'd0);
        chk("t5 line_valid", 64'(line_valid_o), 64'd1);
        chk("t5 line_err",   64'(line_err_o),   64'd1);
        for (int i = 0; i < 8; i++) chk($sformatf("t5 slot%0d", i), line_data_o[64*i +: 64], 64'h100 + 64'(i));
        tick();
        chk("t5 pulses", 64'(lv_cnt), 64'd5);

        // Flush during REQ: burst issued and drained, no line delivered.
        miss_valid_i = 1'b1;
        miss_addr_i  = 64'h6000;
        tick();
        miss_valid_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t6 arvalid kept", 64'(arvalid_o), 64'd1);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        send_beats(8, 7, 64'h600, -1, -1, stalls);
        chk("t6 stalls",     64'(stalls),       64'd0);
        chk("t6 line_valid", 64'(line_valid_o), 64'd0);
        chk("t6 miss_ready", 64'(miss_ready_o), 64'd1);
        tick();

        // Flush in the middle of RESP.
        run_miss(64'h7000, 64'h7000);
        send_beats(8, 7, 64'h700, -1, 3, stalls);
        chk("t7 stalls",     64'(stalls),       64'd0);
        chk("t7 line_valid", 64'(line_valid_o), 64'd0);
        chk("t7 miss_ready", 64'(miss_ready_o), 64'd1);
        tick();
        chk("t7 pulses", 64'(lv_cnt), 64'd5);

        // Reset in the middle of RESP.
        run_miss(64'h8000, 64'h8000);
        send_beats(3, 99, 64'h800, -1, -1, stalls);
        chk("t8 mid rready", 64'(rready_o), 64'd1);
        cpu_reset = 1'b1;
        #2;
        chk_reset_outputs("t8 rst");
        tick();
        cpu_reset = 1'b0;
        tick();
        chk("t8 miss_ready", 64'(miss_ready_o), 64'd1);
        run_miss(64'h1234, 64'h1200);
        send_beats(8, 7, 64'd0, -1, -1, stalls);
        chk("t8 line_valid", 64'(line_valid_o), 64'd1);
        chk("t8 line_err",   64'(line_err_o),   64'd0);
        chk("t8 line_addr",  line_addr_o,       64'h1200);
        chk("t8 slot3",      line_data_o[255:192], 64'd3);
        tick();
        chk("t8 pulses", 64'(lv_cnt), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
